uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin byte scheduler in front of a UART transmitter. It accepts one
// byte at a time from NREQ requesters and hands it to the transmitter with a
// single write strobe. It then waits for the shift register to drain before
// accepting the next byte. A break request takes priority over data and is
// held for at least BREAK_CLKS cycles of txclk.
//
// Optional feature: define UART_TX_SCHED_PARITY_EN to send a parity bit.
// tx_din[8] then carries the XOR of the byte, inverted when PARITY_ODD=1.
// Without the macro, tx_parity and tx_din[8] are tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for tx_empty; arbitrates break and requesters
// LOAD  | one-cycle tx_we strobe; advances the round-robin pointer
// WAIT  | transmitter busy; first cycle ignores tx_empty
// BREAK | driving break; counter runs down, then waits for brk_req low

module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int BREAK_CLKS = 192,
    parameter int PARITY_ODD = 0
) (
    input  logic                    txclk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    brk_req,
    output logic                    brk_active,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    tx_we,
    output logic [8:0]              tx_din,
    output logic                    tx_parity,
    output logic                    tx_break,
    input  logic                    tx_empty
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(BREAK_CLKS + 1);
    localparam logic [CW-1:0]  BRK_LOAD = CW'(BREAK_CLKS - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);
    localparam logic           LP_ODD   = (PARITY_ODD != 0);

`ifdef UART_TX_SCHED_PARITY_EN
    localparam logic LP_PAR_EN = 1'b1;
`else
    localparam logic LP_PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WAIT  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [8:0]       r_tx_din;
    logic [CW-1:0]    r_brk_cnt;
    logic             r_armed;
    logic             r_wait_first;

    logic             w_any;
    logic [IDW-1:0]   w_winner;
    logic [7:0]       w_byte;
    logic             w_par;
    logic             w_accept;
    logic             w_brk_start;

    // Index base+off folded back into 0..NREQ-1 (off is always below NREQ).
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Round-robin search: first valid requester at or above ptr, with wrap.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && req_valid[rr_idx(r_ptr, k)]) begin
                w_any    = 1'b1;
                w_winner = rr_idx(r_ptr, k);
            end
        end
    end

    // Mux out the winner's byte and compute its parity bit.
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_byte = req_data[8*i +: 8];
            end
        end
        w_par = LP_PAR_EN & ((^w_byte) ^ LP_ODD);
    end

    // State register.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Break wins over data. Nothing starts until the
    // block has seen one clock edge out of reset and the transmitter is empty.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_brk_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && tx_empty) begin
                    if (brk_req) begin
                        w_brk_start = 1'b1;
                        w_next      = S_BREAK;
                    end else if (w_any) begin
                        w_accept = 1'b1;
                        w_next   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // The transmitter may not have dropped tx_empty yet in the
                // first WAIT cycle, so it is not trusted there.
                if (!r_wait_first && tx_empty) begin
                    w_next = S_IDLE;
                end
            end
            S_BREAK: begin
                if ((r_brk_cnt == '0) && !brk_req) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // One-hot accept strobe, only in the accepting IDLE cycle.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // Datapath: grant, byte latch, pointer, break counter, arming flags.
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_grant_id   <= '0;
            r_tx_din     <= 9'h000;
            r_brk_cnt    <= '0;
            r_armed      <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            r_wait_first <= (r_state == S_LOAD);
            if (w_accept) begin
                r_grant_id <= w_winner;
                r_tx_din   <= {w_par, w_byte};
            end
            if (r_state == S_LOAD) begin
                r_ptr <= (r_grant_id == ID_LAST) ? '0 : r_grant_id + 1'b1;
            end
            if (w_brk_start) begin
                r_brk_cnt <= BRK_LOAD;
            end else if ((r_state == S_BREAK) && (r_brk_cnt != '0)) begin
                r_brk_cnt <= r_brk_cnt - 1'b1;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign tx_we      = (r_state == S_LOAD);
    assign tx_break   = (r_state == S_BREAK);
    assign brk_active = (r_state == S_BREAK);
    assign grant_id   = r_grant_id;
    assign tx_din     = r_tx_din;
    assign tx_parity  = LP_PAR_EN;

endmodule
